// File: rtl/clock_bank.sv
// Multi-channel programmable divided clock and period tick with shadowed, glitch-free reprogramming.
// Optional CLOCK_BANK_SYNC_EN adds i_sync, which zeroes all channel counters to phase-align them.
module clock_bank #(
    parameter int p_channels = 4,
    parameter int p_width    = 16,
    parameter int p_div      = 49,
    parameter int p_high     = 25,
    localparam int CHW       = (p_channels > 1) ? $clog2(p_channels) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [p_channels-1:0] i_stop,
    input  logic                  i_wr,
    input  logic [CHW-1:0]        i_ch,
    input  logic [p_width-1:0]    i_div,
    input  logic [p_width-1:0]    i_high,
`ifdef CLOCK_BANK_SYNC_EN
    input  logic                  i_sync,
`endif
    output logic [p_channels-1:0] o_out,
    output logic [p_channels-1:0] o_tick,
    output logic [p_channels-1:0] o_pend
);

    logic [p_width-1:0]    cnt_q    [p_channels];
    logic [p_width-1:0]    cnt_d    [p_channels];
    logic [p_width-1:0]    div_q    [p_channels];
    logic [p_width-1:0]    div_d    [p_channels];
    logic [p_width-1:0]    high_q   [p_channels];
    logic [p_width-1:0]    high_d   [p_channels];
    logic [p_width-1:0]    div_s_q  [p_channels];
    logic [p_width-1:0]    div_s_d  [p_channels];
    logic [p_width-1:0]    high_s_q [p_channels];
    logic [p_width-1:0]    high_s_d [p_channels];
    logic [p_channels-1:0] pend_q, pend_d;
    logic [p_channels-1:0] out_q, out_d;
    logic [p_channels-1:0] tick_q, tick_d;

    always_comb begin
        for (int k = 0; k < p_channels; k++) begin
            cnt_d[k]    = cnt_q[k];
            div_d[k]    = div_q[k];
            high_d[k]   = high_q[k];
            div_s_d[k]  = div_s_q[k];
            high_s_d[k] = high_s_q[k];
            pend_d[k]   = pend_q[k];
            out_d[k]    = out_q[k];
            tick_d[k]   = 1'b0;

            if (!i_stop[k]) begin
                out_d[k]  = (cnt_q[k] < high_q[k]);
                tick_d[k] = (cnt_q[k] == '0);
                if (cnt_q[k] == div_q[k]) begin
                    cnt_d[k] = '0;
                    // Shadow values only take effect on the wrap, so a period is never cut short.
                    if (pend_q[k]) begin
                        div_d[k]  = div_s_q[k];
                        high_d[k] = high_s_q[k];
                        pend_d[k] = 1'b0;
                    end
                end else begin
                    cnt_d[k] = cnt_q[k] + p_width'(1);
                end
            end

`ifdef CLOCK_BANK_SYNC_EN
            if (i_sync) begin
                cnt_d[k] = '0;
                if (pend_q[k]) begin
                    div_d[k]  = div_s_q[k];
                    high_d[k] = high_s_q[k];
                end
                pend_d[k] = 1'b0;
            end
`endif

            // Applied last so a write coinciding with a wrap or sync stays pending.
            // Out-of-range channel indices match no k and are dropped.
            if (i_wr && (i_ch == CHW'(k))) begin
                div_s_d[k]  = i_div;
                high_s_d[k] = i_high;
                pend_d[k]   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < p_channels; k++) begin
                cnt_q[k]    <= '0;
                div_q[k]    <= p_width'(p_div);
                high_q[k]   <= p_width'(p_high);
                div_s_q[k]  <= p_width'(p_div);
                high_s_q[k] <= p_width'(p_high);
            end
            pend_q <= '0;
            out_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int k = 0; k < p_channels; k++) begin
                cnt_q[k]    <= cnt_d[k];
                div_q[k]    <= div_d[k];
                high_q[k]   <= high_d[k];
                div_s_q[k]  <= div_s_d[k];
                high_s_q[k] <= high_s_d[k];
            end
            pend_q <= pend_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign o_out  = out_q;
    assign o_tick = tick_q;
    assign o_pend = pend_q;

endmodule

// File: tb/tb_clock_bank.sv
// Self-checking bench for clock_bank: directed scenarios plus randomized traffic against a period-position model.
module tb_clock_bank;

    localparam int NCH  = 4;
    localparam int W    = 16;
    localparam int DIV  = 49;
    localparam int HIGH = 25;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [NCH-1:0] i_stop;
    logic           i_wr;
    logic [1:0]     i_ch;
    logic [W-1:0]   i_div;
    logic [W-1:0]   i_high;
`ifdef CLOCK_BANK_SYNC_EN
    logic           i_sync;
`endif
    logic [NCH-1:0] o_out;
    logic [NCH-1:0] o_tick;
    logic [NCH-1:0] o_pend;

    clock_bank #(.p_channels(NCH), .p_width(W), .p_div(DIV), .p_high(HIGH)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_stop (i_stop),
        .i_wr   (i_wr),
        .i_ch   (i_ch),
        .i_div  (i_div),
        .i_high (i_high),
`ifdef CLOCK_BANK_SYNC_EN
        .i_sync (i_sync),
`endif
        .o_out  (o_out),
        .o_tick (o_tick),
        .o_pend (o_pend)
    );

    always #5 i_clk = ~i_clk;

    // Reference: each channel is described by its position inside the current period,
    // the period/high settings in force, and the settings queued for the next period.
    int             m_pos   [NCH];
    int             m_div   [NCH];
    int             m_high  [NCH];
    int             m_ndiv  [NCH];
    int             m_nhigh [NCH];
    logic [NCH-1:0] m_out, m_tick, m_pend;

    int n_vec = 0;
    int n_err = 0;

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_pos[k] = 0; m_div[k] = DIV; m_high[k] = HIGH;
            m_ndiv[k] = DIV; m_nhigh[k] = HIGH;
        end
        m_out = '0; m_tick = '0; m_pend = '0;
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < NCH; k++) begin
            if (!i_stop[k]) begin
                m_out[k]  = (m_pos[k] < m_high[k]);
                m_tick[k] = (m_pos[k] == 0);
                m_pos[k]  = (m_pos[k] + 1) % (m_div[k] + 1);
                if (m_pos[k] == 0 && m_pend[k]) begin
                    m_div[k] = m_ndiv[k]; m_high[k] = m_nhigh[k]; m_pend[k] = 1'b0;
                end
            end else begin
                m_tick[k] = 1'b0;
            end
`ifdef CLOCK_BANK_SYNC_EN
            if (i_sync) begin
                m_pos[k] = 0;
                if (m_pend[k]) begin
                    m_div[k] = m_ndiv[k]; m_high[k] = m_nhigh[k]; m_pend[k] = 1'b0;
                end
            end
`endif
            if (i_wr && int'(i_ch) == k) begin
                m_ndiv[k] = int'(i_div); m_nhigh[k] = int'(i_high); m_pend[k] = 1'b1;
            end
        end
    endfunction

    task automatic cycle();
        model_edge();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_pos(input int k, input int p);
        int n;
        n = 0;
        while (m_pos[k] != p && n < 200) begin
            cycle();
            n++;
        end
        if (m_pos[k] != p) begin
            n_err++;
            $display("FAIL wait_pos ch%0d: position %0d required %0d", k, m_pos[k], p);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0; i_stop = '0; i_wr = 1'b0; i_ch = '0; i_div = '0; i_high = '0;
`ifdef CLOCK_BANK_SYNC_EN
        i_sync = 1'b0;
`endif
        model_reset();
        #12;
        n_vec++;
        if ({o_out, o_tick, o_pend} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_state: got %h required 000", {o_out, o_tick, o_pend});
        end
        i_rst = 1'b1;
        cycle();
        n_vec++;
        if (o_tick !== 4'hF || o_out !== 4'hF || o_pend !== 4'h0) begin
            n_err++;
            $display("FAIL first_edge: out/tick/pend got %h/%h/%h required f/f/0", o_out, o_tick, o_pend);
        end
    endtask

    task automatic test_defaults();
        int last, hc, c;
        bit seen;
        seen = 1'b0; hc = 0; last = 0;
        for (c = 0; c < 160; c++) begin
            cycle();
            n_vec++;
            if ({o_out, o_tick, o_pend} !== {m_out, m_tick, m_pend}) begin
                n_err++;
                $display("FAIL defaults c%0d: got %h required %h", c, {o_out, o_tick, o_pend}, {m_out, m_tick, m_pend});
            end
            if (o_tick[0]) begin
                if (seen) begin
                    n_vec++;
                    if (c - last != 50 || hc != 25) begin
                        n_err++;
                        $display("FAIL defaults_period: gap %0d high %0d required 50 25", c - last, hc);
                    end
                end
                seen = 1'b1; last = c; hc = 0;
            end
            hc += int'(o_out[0]);
        end
    endtask

    task automatic test_reprogram();
        int pc, last, hc;
        bit seen;
        pc = 0; seen = 1'b0; last = 0; hc = 0;
        wait_pos(1, 20);
        i_wr = 1'b1; i_ch = 2'd1; i_div = 16'd9; i_high = 16'd3;
        for (int c = 0; c < 60; c++) begin
            cycle();
            i_wr = 1'b0;
            n_vec++;
            if ({o_out, o_tick, o_pend} !== {m_out, m_tick, m_pend}) begin
                n_err++;
                $display("FAIL reprogram c%0d: got %h required %h", c, {o_out, o_tick, o_pend}, {m_out, m_tick, m_pend});
            end
            pc += int'(o_pend[1]);
            if (o_tick[1]) begin
                if (seen) begin
                    n_vec++;
                    if (c - last != 10 || hc != 3) begin
                        n_err++;
                        $display("FAIL reprogram_period: gap %0d high %0d required 10 3", c - last, hc);
                    end
                end
                seen = 1'b1; last = c; hc = 0;
            end
            hc += int'(o_out[1]);
        end
        n_vec++;
        if (pc != 29) begin
            n_err++;
            $display("FAIL reprogram_pend_len: got %0d required 29", pc);
        end
    endtask

    task automatic test_last_write();
        int last, gap;
        last = -1; gap = 0;
        wait_pos(2, 10);
        for (int c = 0; c < 90; c++) begin
            i_wr = (c < 2); i_ch = 2'd2;
            i_div = (c == 0) ? 16'd4 : 16'd7; i_high = (c == 0) ? 16'd2 : 16'd3;
            cycle();
            n_vec++;
            if ({o_out, o_tick, o_pend} !== {m_out, m_tick, m_pend}) begin
                n_err++;
                $display("FAIL last_write c%0d: got %h required %h", c, {o_out, o_tick, o_pend}, {m_out, m_tick, m_pend});
            end
            if (o_tick[2]) begin
                if (last >= 0) gap = c - last;
                last = c;
            end
        end
        i_wr = 1'b0;
        n_vec++;
        if (gap != 8) begin
            n_err++;
            $display("FAIL last_write_period: gap %0d required 8", gap);
        end
    endtask

    task automatic test_stop();
        int run;
        bit done;
        run = 0; done = 1'b0;
        wait_pos(0, 10);
        i_stop = 4'b0001;
        for (int c = 0; c < 100; c++) begin
            cycle();
            n_vec++;
            if (o_out[0] !== 1'b1 || o_tick[0] !== 1'b0 || {o_out, o_tick, o_pend} !== {m_out, m_tick, m_pend}) begin
                n_err++;
                $display("FAIL stop_hold c%0d: got %h required %h", c, {o_out, o_tick, o_pend}, {m_out, m_tick, m_pend});
            end
        end
        i_stop = '0;
        for (int c = 0; c < 60; c++) begin
            cycle();
            n_vec++;
            if ({o_out, o_tick, o_pend} !== {m_out, m_tick, m_pend}) begin
                n_err++;
                $display("FAIL stop_resume c%0d: got %h required %h", c, {o_out, o_tick, o_pend}, {m_out, m_tick, m_pend});
            end
            if (!done && o_out[0]) run++;
            if (!o_out[0]) done = 1'b1;
        end
        n_vec++;
        if (run != 15) begin
            n_err++;
            $display("FAIL stop_remaining_high: got %0d required 15", run);
        end
    endtask

    task automatic test_degenerate();
        for (int c = 0; c < 130; c++) begin
            i_wr = (c < 3);
            i_ch = (c == 0) ? 2'd3 : (c == 1) ? 2'd2 : 2'd1;
            i_div = (c == 2) ? 16'd0 : 16'd49;
            i_high = (c == 0) ? 16'd0 : (c == 1) ? 16'd60 : 16'd5;
            cycle();
            n_vec++;
            if ({o_out, o_tick, o_pend} !== {m_out, m_tick, m_pend}) begin
                n_err++;
                $display("FAIL degenerate c%0d: got %h required %h", c, {o_out, o_tick, o_pend}, {m_out, m_tick, m_pend});
            end
            if (c >= 120) begin
                n_vec++;
                if (o_out[3] !== 1'b0 || o_out[2] !== 1'b1 || o_tick[1] !== 1'b1 || o_out[1] !== 1'b1) begin
                    n_err++;
                    $display("FAIL degenerate_levels c%0d: out %b tick %b required out 011x tick xx1x", c, o_out, o_tick);
                end
            end
        end
        i_wr = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 700; c++) begin
            i_wr   = ($urandom_range(0, 3) == 0);
            i_ch   = 2'($urandom_range(0, 3));
            i_div  = 16'($urandom_range(0, 12));
            i_high = 16'($urandom_range(0, 14));
            for (int k = 0; k < NCH; k++)
                if ($urandom_range(0, 7) == 0) i_stop[k] = ~i_stop[k];
            cycle();
            n_vec++;
            if ({o_out, o_tick, o_pend} !== {m_out, m_tick, m_pend}) begin
                n_err++;
                $display("FAIL random c%0d: got %h required %h", c, {o_out, o_tick, o_pend}, {m_out, m_tick, m_pend});
            end
        end
        i_wr = 1'b0; i_stop = '0;
    endtask

`ifdef CLOCK_BANK_SYNC_EN
    task automatic test_sync();
        for (int c = 0; c < 80; c++) begin
            i_wr = (c < 3); i_ch = 2'(c);
            i_div = (c == 0) ? 16'd49 : (c == 1) ? 16'd9 : 16'd4;
            i_high = 16'd2;
            cycle();
        end
        i_sync = 1'b1; i_wr = 1'b1; i_ch = 2'd3; i_div = 16'd6; i_high = 16'd3;
        cycle();
        i_sync = 1'b0; i_wr = 1'b0;
        n_vec++;
        if (o_pend !== 4'b1000 || {o_out, o_tick, o_pend} !== {m_out, m_tick, m_pend}) begin
            n_err++;
            $display("FAIL sync_edge: got %h required %h", {o_out, o_tick, o_pend}, {m_out, m_tick, m_pend});
        end
        cycle();
        n_vec++;
        if (o_tick !== 4'hF) begin
            n_err++;
            $display("FAIL sync_align: tick %b required 1111", o_tick);
        end
        for (int c = 0; c < 40; c++) begin
            cycle();
            n_vec++;
            if ({o_out, o_tick, o_pend} !== {m_out, m_tick, m_pend}) begin
                n_err++;
                $display("FAIL sync_after c%0d: got %h required %h", c, {o_out, o_tick, o_pend}, {m_out, m_tick, m_pend});
            end
        end
    endtask
`endif

    task automatic test_reset_pending();
        i_wr = 1'b1; i_ch = 2'd0; i_div = 16'd5; i_high = 16'd1;
        cycle();
        i_wr = 1'b0;
        #3;
        i_rst = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({o_out, o_tick, o_pend} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_async: got %h required 000", {o_out, o_tick, o_pend});
        end
        #2;
        i_rst = 1'b1;
        for (int c = 0; c < 60; c++) begin
            cycle();
            n_vec++;
            if ({o_out, o_tick, o_pend} !== {m_out, m_tick, m_pend} || (c == 0 && o_tick !== 4'hF)) begin
                n_err++;
                $display("FAIL reset_pending c%0d: got %h required %h", c, {o_out, o_tick, o_pend}, {m_out, m_tick, m_pend});
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_reprogram();
        test_last_write();
        test_stop();
        test_degenerate();
        test_random();
`ifdef CLOCK_BANK_SYNC_EN
        test_sync();
`endif
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
